// File: rtl/ysyx_22050598_lsu.sv
// ============================================================================
// Module   : ysyx_22050598_lsu
// Brief    : Load/store unit with a single-outstanding bus request, lane
//            shifting for stores and sign/zero extraction for loads.
//            Optional macro YSYX_22050598_LSU_MISALIGN_CHECK_EN traps
//            misaligned H/W/D accesses instead of issuing them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050598_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        lsu_ready_o,
    input  logic        ex_load_en,
    input  logic        ex_store_en,
    input  logic [1:0]  ex_ls_size,
    input  logic        ex_load_unsigned,
    input  logic [63:0] ex_alu_rd_ls_data,
    input  logic [63:0] ex_store_data,
    input  logic [4:0]  ex_rd_idx,
    input  logic        ex_write_reg_en,
    input  logic        mem_flush,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    output logic        lsu_req_write,
    output logic [63:0] lsu_req_addr,
    output logic [63:0] lsu_req_wdata,
    output logic [7:0]  lsu_req_wstrb,
    input  logic        lsu_rsp_valid,
    input  logic [63:0] lsu_rsp_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_idx,
    output logic [63:0] wb_rd_data,
    output logic        wb_write_reg_en,
    output logic        lsu_misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        is_store_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [4:0]  rd_idx_q;
    logic        wen_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_idx_q;
    logic [63:0] wb_rd_data_q;
    logic        wb_wen_q;

    logic [2:0]  w_off;
    logic [7:0]  w_mask;
    logic [7:0]  w_wstrb;
    logic [63:0] w_wdata;
    logic [63:0] w_rshift;
    logic [63:0] w_load_data;
    logic        w_misalign;

    assign w_off   = ex_alu_rd_ls_data[2:0];
    // 8-bit shift drops strobes that would spill past the doubleword.
    assign w_wstrb = w_mask << w_off;
    assign w_wdata = ex_store_data << {w_off, 3'b000};

    always_comb begin
        w_mask = 8'h00;
        case (ex_ls_size)
            2'd0:    w_mask = 8'h01;
            2'd1:    w_mask = 8'h03;
            2'd2:    w_mask = 8'h0F;
            default: w_mask = 8'hFF;
        endcase
    end

`ifdef YSYX_22050598_LSU_MISALIGN_CHECK_EN
    logic misalign_q;

    always_comb begin
        w_misalign = 1'b0;
        case (ex_ls_size)
            2'd1:    w_misalign = w_off[0];
            2'd2:    w_misalign = |w_off[1:0];
            2'd3:    w_misalign = |w_off;
            default: w_misalign = 1'b0;
        endcase
    end

    assign lsu_misalign_o = misalign_q;
`else
    assign w_misalign     = 1'b0;
    assign lsu_misalign_o = 1'b0;
`endif

    assign w_rshift = lsu_rsp_rdata >> {addr_q[2:0], 3'b000};

    always_comb begin
        w_load_data = 64'd0;
        case (size_q)
            2'd0: w_load_data = unsigned_q ? {56'd0, w_rshift[7:0]}
                                           : {{56{w_rshift[7]}}, w_rshift[7:0]};
            2'd1: w_load_data = unsigned_q ? {48'd0, w_rshift[15:0]}
                                           : {{48{w_rshift[15]}}, w_rshift[15:0]};
            2'd2: w_load_data = unsigned_q ? {32'd0, w_rshift[31:0]}
                                           : {{32{w_rshift[31]}}, w_rshift[31:0]};
            default: w_load_data = w_rshift;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            is_store_q   <= 1'b0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            rd_idx_q     <= '0;
            wen_q        <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_idx_q  <= '0;
            wb_rd_data_q <= '0;
            wb_wen_q     <= 1'b0;
`ifdef YSYX_22050598_LSU_MISALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            wb_valid_q <= 1'b0;
`ifdef YSYX_22050598_LSU_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (ex_valid && !mem_flush) begin
                        if (ex_load_en || ex_store_en) begin
                            if (w_misalign) begin
                                wb_valid_q   <= 1'b1;
                                wb_rd_idx_q  <= ex_rd_idx;
                                wb_rd_data_q <= '0;
                                wb_wen_q     <= 1'b0;
`ifdef YSYX_22050598_LSU_MISALIGN_CHECK_EN
                                misalign_q   <= 1'b1;
`endif
                            end else begin
                                addr_q     <= ex_alu_rd_ls_data;
                                is_store_q <= ex_store_en;
                                wdata_q    <= ex_store_en ? w_wdata : 64'd0;
                                wstrb_q    <= ex_store_en ? w_wstrb : 8'd0;
                                size_q     <= ex_ls_size;
                                unsigned_q <= ex_load_unsigned;
                                rd_idx_q   <= ex_rd_idx;
                                wen_q      <= ex_write_reg_en;
                                state_q    <= S_REQ;
                            end
                        end else begin
                            wb_valid_q   <= 1'b1;
                            wb_rd_idx_q  <= ex_rd_idx;
                            wb_rd_data_q <= ex_alu_rd_ls_data;
                            wb_wen_q     <= ex_write_reg_en;
                        end
                    end
                end
                S_REQ: begin
                    // A flush landing on the handshake still owes us a response.
                    if (mem_flush) begin
                        state_q <= lsu_req_ready ? S_DROP : S_IDLE;
                    end else if (lsu_req_ready) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (lsu_rsp_valid) begin
                        state_q <= S_IDLE;
                        if (!mem_flush) begin
                            wb_valid_q   <= 1'b1;
                            wb_rd_idx_q  <= rd_idx_q;
                            wb_rd_data_q <= is_store_q ? 64'd0 : w_load_data;
                            wb_wen_q     <= is_store_q ? 1'b0 : wen_q;
                        end
                    end else if (mem_flush) begin
                        state_q <= S_DROP;
                    end
                end
                default: begin
                    if (lsu_rsp_valid) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign lsu_ready_o     = (state_q == S_IDLE);
    assign lsu_req_valid   = (state_q == S_REQ);
    assign lsu_req_write   = is_store_q;
    assign lsu_req_addr    = {addr_q[63:3], 3'b000};
    assign lsu_req_wdata   = wdata_q;
    assign lsu_req_wstrb   = wstrb_q;
    assign wb_valid        = wb_valid_q;
    assign wb_rd_idx       = wb_rd_idx_q;
    assign wb_rd_data      = wb_rd_data_q;
    assign wb_write_reg_en = wb_wen_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050598_lsu.sv
// ============================================================================
// Module   : tb_ysyx_22050598_lsu
// Brief    : Directed self-checking bench for ysyx_22050598_lsu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22050598_lsu;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        lsu_ready_o;
    logic        ex_load_en;
    logic        ex_store_en;
    logic [1:0]  ex_ls_size;
    logic        ex_load_unsigned;
    logic [63:0] ex_alu_rd_ls_data;
    logic [63:0] ex_store_data;
    logic [4:0]  ex_rd_idx;
    logic        ex_write_reg_en;
    logic        mem_flush;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_req_write;
    logic [63:0] lsu_req_addr;
    logic [63:0] lsu_req_wdata;
    logic [7:0]  lsu_req_wstrb;
    logic        lsu_rsp_valid;
    logic [63:0] lsu_rsp_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd_idx;
    logic [63:0] wb_rd_data;
    logic        wb_write_reg_en;
    logic        lsu_misalign_o;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22050598_lsu u_dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid          (ex_valid),
        .lsu_ready_o       (lsu_ready_o),
        .ex_load_en        (ex_load_en),
        .ex_store_en       (ex_store_en),
        .ex_ls_size        (ex_ls_size),
        .ex_load_unsigned  (ex_load_unsigned),
        .ex_alu_rd_ls_data (ex_alu_rd_ls_data),
        .ex_store_data     (ex_store_data),
        .ex_rd_idx         (ex_rd_idx),
        .ex_write_reg_en   (ex_write_reg_en),
        .mem_flush         (mem_flush),
        .lsu_req_valid     (lsu_req_valid),
        .lsu_req_ready     (lsu_req_ready),
        .lsu_req_write     (lsu_req_write),
        .lsu_req_addr      (lsu_req_addr),
        .lsu_req_wdata     (lsu_req_wdata),
        .lsu_req_wstrb     (lsu_req_wstrb),
        .lsu_rsp_valid     (lsu_rsp_valid),
        .lsu_rsp_rdata     (lsu_rsp_rdata),
        .wb_valid          (wb_valid),
        .wb_rd_idx         (wb_rd_idx),
        .wb_rd_data        (wb_rd_data),
        .wb_write_reg_en   (wb_write_reg_en),
        .lsu_misalign_o    (lsu_misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one EX op for exactly one cycle.
    task automatic issue(input logic ld, input logic st, input logic [1:0] size,
                         input logic uns, input logic [63:0] addr,
                         input logic [63:0] sdata, input logic [4:0] rd, input logic wen);
        ex_valid          = 1'b1;
        ex_load_en        = ld;
        ex_store_en       = st;
        ex_ls_size        = size;
        ex_load_unsigned  = uns;
        ex_alu_rd_ls_data = addr;
        ex_store_data     = sdata;
        ex_rd_idx         = rd;
        ex_write_reg_en   = wen;
        tick();
        ex_valid    = 1'b0;
        ex_load_en  = 1'b0;
        ex_store_en = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                           input logic uns, input logic [63:0] rdata, input logic [63:0] exp);
        issue(1'b1, 1'b0, size, uns, addr, 64'd0, 5'd10, 1'b1);
        check({tag, " req_valid"}, {63'd0, lsu_req_valid}, 64'd1);
        check({tag, " req_addr"}, lsu_req_addr, {addr[63:3], 3'b000});
        check({tag, " wstrb"}, {56'd0, lsu_req_wstrb}, 64'd0);
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        check({tag, " req_drop"}, {63'd0, lsu_req_valid}, 64'd0);
        lsu_rsp_valid = 1'b1;
        lsu_rsp_rdata = rdata;
        tick();
        lsu_rsp_valid = 1'b0;
        check({tag, " wb_valid"}, {63'd0, wb_valid}, 64'd1);
        check({tag, " wb_data"}, wb_rd_data, exp);
        check({tag, " wb_wen"}, {63'd0, wb_write_reg_en}, 64'd1);
        tick();
        check({tag, " wb_pulse"}, {63'd0, wb_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_load_en = 1'b0; ex_store_en = 1'b0; ex_ls_size = 2'd0;
        ex_load_unsigned = 1'b0; ex_alu_rd_ls_data = 64'd0; ex_store_data = 64'd0;
        ex_rd_idx = 5'd0; ex_write_reg_en = 1'b0; mem_flush = 1'b0;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rsp_rdata = 64'd0;
        #2 rst = 1'b0;
        tick();
        tick();
        check("rst ready", {63'd0, lsu_ready_o}, 64'd1);
        check("rst req_valid", {63'd0, lsu_req_valid}, 64'd0);
        check("rst wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst wb_data", wb_rd_data, 64'd0);
        check("rst misalign", {63'd0, lsu_misalign_o}, 64'd0);
        rst = 1'b1;
        tick();

        // Non-memory pass-through
        issue(1'b0, 1'b0, 2'd0, 1'b0, 64'h1234, 64'd0, 5'd5, 1'b1);
        check("alu wb_valid", {63'd0, wb_valid}, 64'd1);
        check("alu wb_data", wb_rd_data, 64'h1234);
        check("alu wb_idx", {59'd0, wb_rd_idx}, 64'd5);
        check("alu wb_wen", {63'd0, wb_write_reg_en}, 64'd1);
        check("alu ready", {63'd0, lsu_ready_o}, 64'd1);
        tick();
        check("alu pulse", {63'd0, wb_valid}, 64'd0);

        // Loads
        do_load("lw", 64'h80000004, 2'd2, 1'b0, 64'h8765432100000000, 64'hFFFFFFFF87654321);
        do_load("lhu", 64'h80000006, 2'd1, 1'b1, 64'h8765432100000000, 64'h0000000000008765);
        do_load("lb", 64'h80000007, 2'd0, 1'b0, 64'h8765432100000000, 64'hFFFFFFFFFFFFFF87);
        do_load("lwu", 64'h80000004, 2'd2, 1'b1, 64'h8765432100000000, 64'h0000000087654321);
        do_load("ld", 64'h80000008, 2'd3, 1'b0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);

        // SB with bus stalled three cycles
        issue(1'b0, 1'b1, 2'd0, 1'b0, 64'h80000003, 64'hAB, 5'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("sb req_valid", {63'd0, lsu_req_valid}, 64'd1);
            check("sb write", {63'd0, lsu_req_write}, 64'd1);
            check("sb addr", lsu_req_addr, 64'h80000000);
            check("sb wstrb", {56'd0, lsu_req_wstrb}, 64'h08);
            check("sb wdata", lsu_req_wdata, 64'h00000000AB000000);
            if (i < 3) tick();
        end
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        tick();
        check("sb no early wb", {63'd0, wb_valid}, 64'd0);
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        check("sb wb_valid", {63'd0, wb_valid}, 64'd1);
        check("sb wb_wen", {63'd0, wb_write_reg_en}, 64'd0);
        tick();
        check("sb pulse", {63'd0, wb_valid}, 64'd0);

        // Flush during RESP
        issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h80000010, 64'd0, 5'd9, 1'b1);
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        mem_flush = 1'b1;
        tick();
        mem_flush = 1'b0;
        check("flresp ready", {63'd0, lsu_ready_o}, 64'd0);
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        check("flresp no wb", {63'd0, wb_valid}, 64'd0);
        check("flresp idle", {63'd0, lsu_ready_o}, 64'd1);
        issue(1'b0, 1'b0, 2'd0, 1'b0, 64'h55, 64'd0, 5'd7, 1'b1);
        check("flresp next wb", {63'd0, wb_valid}, 64'd1);
        check("flresp next data", wb_rd_data, 64'h55);

        // Flush in REQ before handshake
        issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h80000018, 64'd0, 5'd9, 1'b1);
        mem_flush = 1'b1;
        tick();
        mem_flush = 1'b0;
        check("flreq req_valid", {63'd0, lsu_req_valid}, 64'd0);
        check("flreq ready", {63'd0, lsu_ready_o}, 64'd1);
        check("flreq no wb", {63'd0, wb_valid}, 64'd0);

        // Flush coincident with handshake
        issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h80000020, 64'd0, 5'd9, 1'b1);
        mem_flush = 1'b1;
        lsu_req_ready = 1'b1;
        tick();
        mem_flush = 1'b0;
        lsu_req_ready = 1'b0;
        check("flhs req_valid", {63'd0, lsu_req_valid}, 64'd0);
        check("flhs drop", {63'd0, lsu_ready_o}, 64'd0);
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        check("flhs no wb", {63'd0, wb_valid}, 64'd0);
        check("flhs idle", {63'd0, lsu_ready_o}, 64'd1);

        // Flush in IDLE, stray response in IDLE
        mem_flush = 1'b1;
        issue(1'b0, 1'b0, 2'd0, 1'b0, 64'h77, 64'd0, 5'd4, 1'b1);
        mem_flush = 1'b0;
        check("flidle no wb", {63'd0, wb_valid}, 64'd0);
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        check("stray rsp", {63'd0, wb_valid}, 64'd0);

`ifdef YSYX_22050598_LSU_MISALIGN_CHECK_EN
        issue(1'b1, 1'b0, 2'd1, 1'b0, 64'h80000001, 64'd0, 5'd6, 1'b1);
        check("mis req_valid", {63'd0, lsu_req_valid}, 64'd0);
        check("mis wb_valid", {63'd0, wb_valid}, 64'd1);
        check("mis flag", {63'd0, lsu_misalign_o}, 64'd1);
        check("mis wb_wen", {63'd0, wb_write_reg_en}, 64'd0);
        tick();
        check("mis pulse", {63'd0, lsu_misalign_o}, 64'd0);
`else
        // Misaligned SW proceeds with truncated strobes
        issue(1'b0, 1'b1, 2'd2, 1'b0, 64'h80000006, 64'h11223344, 5'd0, 1'b0);
        check("misw req_valid", {63'd0, lsu_req_valid}, 64'd1);
        check("misw wstrb", {56'd0, lsu_req_wstrb}, 64'hC0);
        check("misw wdata", lsu_req_wdata, 64'h3344000000000000);
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        check("misw wb_valid", {63'd0, wb_valid}, 64'd1);
        check("misw flag", {63'd0, lsu_misalign_o}, 64'd0);
        tick();
`endif

        // Reset mid-transaction, late response ignored
        issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h80000030, 64'd0, 5'd2, 1'b1);
        check("rstmid req_on", {63'd0, lsu_req_valid}, 64'd1);
        rst = 1'b0;
        #1;
        check("rstmid req_off", {63'd0, lsu_req_valid}, 64'd0);
        check("rstmid ready", {63'd0, lsu_ready_o}, 64'd1);
        tick();
        rst = 1'b1;
        lsu_rsp_valid = 1'b1;
        lsu_rsp_rdata = 64'hDEAD;
        tick();
        lsu_rsp_valid = 1'b0;
        check("rstmid late rsp", {63'd0, wb_valid}, 64'd0);
        check("rstmid idle", {63'd0, lsu_ready_o}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_22050598_lsu.md
YSYX_22050598_LSU -- requirements
Module: ysyx_22050598_lsu

Interface
REQ-001 SHALL: clk  in  1  sole clock, rising edge.
REQ-002 SHALL: rst  in  1  reset; asynchronous, active-low.
REQ-003 SHALL: ex_valid  in  1  EX result valid this cycle.
REQ-004 SHALL: lsu_ready_o  out  1  LSU can accept an EX result.
REQ-005 SHALL: ex_load_en  in  1  op is a load.
REQ-006 SHALL: ex_store_en  in  1  op is a store.
REQ-007 SHALL: ex_ls_size  in  2  access size: 0=B, 1=H, 2=W, 3=D.
REQ-008 SHALL: ex_load_unsigned  in  1  zero-extend the load result.
REQ-009 SHALL: ex_alu_rd_ls_data  in  64  L/S byte address, or rd data for non-memory ops.
REQ-010 SHALL: ex_store_data  in  64  store data, LSB-aligned.
REQ-011 SHALL: ex_rd_idx  in  5  destination register.
REQ-012 SHALL: ex_write_reg_en  in  1  op writes rd.
REQ-013 SHALL: mem_flush  in  1  kill the in-flight op.
REQ-014 SHALL: lsu_req_valid  out  1  bus request valid.
REQ-015 SHALL: lsu_req_ready  in  1  bus accepts request.
REQ-016 SHALL: lsu_req_write  out  1  1=store, 0=load.
REQ-017 SHALL: lsu_req_addr  out  64  address with bits [2:0] forced to 0.
REQ-018 SHALL: lsu_req_wdata  out  64  lane-shifted store data.
REQ-019 SHALL: lsu_req_wstrb  out  8  byte strobes; 0 for loads.
REQ-020 SHALL: lsu_rsp_valid  in  1  bus response; exactly one per accepted request, at least 1 cycle after it.
REQ-021 SHALL: lsu_rsp_rdata  in  64  8-byte-aligned read data.
REQ-022 SHALL: wb_valid  out  1  one-cycle pulse per completed op.
REQ-023 SHALL: wb_rd_idx  out  5  destination register to WB.
REQ-024 SHALL: wb_rd_data  out  64  result to WB.
REQ-025 SHALL: wb_write_reg_en  out  1  WB writes rd.
REQ-026 SHALL: lsu_misalign_o  out  1  misaligned-access pulse, aligned with wb_valid.

Function
REQ-027 SHALL: FSM states are IDLE, REQ, RESP, DROP; lsu_ready_o = (state==IDLE).
REQ-028 SHALL: in IDLE, ex_valid with neither load nor store -> next cycle wb_valid=1 with wb_rd_data=ex_alu_rd_ls_data and wb_rd_idx/wb_write_reg_en passed through; state stays IDLE.
REQ-029 SHALL: in IDLE, ex_valid with a load or store -> operands are registered and the FSM goes to REQ; lsu_req_valid=1 from the next cycle and all req outputs stay stable until lsu_req_ready.
REQ-030 SHALL: REQ, on valid&ready -> RESP; RESP, on lsu_rsp_valid -> IDLE; wb_valid=1 the following cycle.
REQ-031 SHALL: store lane/strobe rule, with off = addr[2:0]: wdata = store_data << (8*off); wstrb = ((1<<2^size)-1) << off, truncated to 8 bits.
REQ-032 SHALL: load extraction: d = rdata >> (8*off), truncated to 2^size bytes, then sign-extended (or zero-extended if ex_load_unsigned) to 64 bits; this is wb_rd_data.
REQ-033 SHALL: a store completes with wb_valid=1 and wb_write_reg_en=0.
REQ-034 SHALL: mem_flush in IDLE drops the incoming op (no wb_valid); in REQ before the handshake it deasserts lsu_req_valid next cycle and returns to IDLE.
REQ-035 SHALL: mem_flush in RESP, or coincident with the REQ handshake -> DROP; DROP waits for lsu_rsp_valid, then returns to IDLE with no wb_valid.
REQ-036 SHALL: lsu_rsp_valid outside RESP/DROP is ignored.

Reset
REQ-037 SHALL: on rst=0, state=IDLE and all outputs are 0 (lsu_ready_o reads 1 in IDLE); any pending op is discarded.
REQ-038 SHALL: reset mid-transaction leaves the bus request deasserted, and a late response is ignored.

Configuration
REQ-039 SHALL: with YSYX_22050598_LSU_MISALIGN_CHECK_EN defined, an H/W/D access whose addr is not size-aligned issues no bus request; next cycle wb_valid=1, wb_write_reg_en=0, lsu_misalign_o=1.
REQ-040 SHALL: without YSYX_22050598_LSU_MISALIGN_CHECK_EN, lsu_misalign_o is tied 0 and misaligned accesses proceed with the truncated strobes of REQ-031.

Verification
REQ-041 SHALL: LD addr 0x80000004, size W, signed; rdata=0x8765432100000000 -> wb_rd_data=0xFFFFFFFF87654321.
REQ-042 SHALL: SB addr 0x80000003, data 0xAB -> wstrb=0x08, wdata[31:24]=0xAB, req_addr=0x80000000.
REQ-043 SHALL: lsu_req_ready held low 3 cycles -> req outputs stable; wb_valid exactly 1 cycle after rsp_valid.
REQ-044 SHALL: mem_flush during RESP -> no wb_valid; the next op is accepted after rsp_valid.
REQ-045 SHALL: with the macro defined, LH addr 0x80000001 -> no req_valid; wb_valid=1, lsu_misalign_o=1 next cycle.
REQ-046 SHALL: non-memory op, rd=5, data=0x1234 -> wb_valid next cycle, wb_rd_data=0x1234, wb_rd_idx=5.
